// File: rtl/nibble_serial_add_seq.sv
// rtl/nibble_serial_add_seq.sv - drives a 4-bit adder slice one nibble per clock to build a wide add.
module nibble_serial_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   op_cin,
    output logic [3:0]             add_x,
    output logic [3:0]             add_y,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        sum_q   <= '0;
                        carry_q <= op_cin;
                        idx_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    // The slice is combinational, so its result for this nibble is ready now.
                    sum_q[4*idx_q +: 4] <= add_s;
                    carry_q             <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic adding;
    logic done;
    assign adding = (state_q == ADD);
    assign done   = (state_q == DONE);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = done;

    assign add_x   = adding ? a_q[4*idx_q +: 4] : 4'd0;
    assign add_y   = adding ? b_q[4*idx_q +: 4] : 4'd0;
    assign add_cin = adding ? carry_q : 1'b0;

    // Result outputs are zero outside DONE so partial sums never leak downstream.
    assign out_sum  = done ? sum_q : '0;
    assign out_cout = done ? carry_q : 1'b0;
    assign out_ovf  = done && (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
endmodule
